ex_wb_stage: RTL
================

// Module: ex_wb_stage
// PURPOSE
//  Execute-to-writeback pipeline stage behind the 16-bit ALU. Captures the ALU
//  result, zero/carry flags and destination info each cycle through a
//  valid/ready handshake with a 2-entry skid buffer. Commits entries to the
//  register-file write port and holds the architectural Z/C status register.
//  Keeps a retired-instruction counter.
// PARAMETERS
//  DATA_W  16  width of ALU result / write-back data
//  RD_W    3   destination register index width (8 GPRs)
//  CNT_W   16  retired-instruction counter width
// PORTS
//  clk         in   1       single clock, all state on rising edge
//  rst_n       in   1       synchronous reset, active-low
//  flush       in   1       sync flush: drop all buffered entries
//  in_valid    in   1       upstream entry valid
//  in_ready    out  1       stage can accept (registered)
//  in_result   in   DATA_W  ALU result
//  in_zero     in   1       ALU zero flag
//  in_carry    in   1       ALU carry/borrow flag
//  in_rd       in   RD_W    destination register
//  in_wr_en    in   1       entry writes register file
//  in_flag_en  in   1       entry updates Z/C status
//  out_valid   out  1       write-back entry valid
//  out_ready   in   1       register file / consumer accepts
//  out_result  out  DATA_W  write-back data
//  out_rd      out  RD_W    write-back destination
//  out_wr_en   out  1       gated write enable = out_valid & entry wr_en
//  flag_z      out  1       architectural zero flag
//  flag_c      out  1       architectural carry flag
//  retired     out  CNT_W   count of committed entries
// BEHAVIOUR
//  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  - Reset (rst_n=0 at edge): state EMPTY, out_valid=0, in_ready=1, flag_z=0,
//    flag_c=0, retired=0, data/rd regs=0. Inputs are ignored while rst_n=0.
//  - Storage: MAIN (drives outputs) + SKID. States by occupancy:
//    EMPTY: in_fire -> ONE (MAIN<=in).
//    ONE:   in_fire & out_fire -> ONE (MAIN<=in); in_fire only -> FULL
//           (SKID<=in); out_fire only -> EMPTY.
//    FULL:  in_ready=0; out_fire -> ONE (MAIN<=SKID); else hold.
//  - in_ready is registered: 1 in EMPTY/ONE, 0 in FULL. No combinational
//    path from out_ready to in_ready.
//  - Latency: in_fire at cycle N -> out_valid=1 at N+1 (when not FULL).
//    Throughput: 1 entry/cycle with out_ready held high.
//  - Outputs stable while out_valid=1 and out_ready=0.
//  - Commit on out_fire: if entry flag_en then flag_z<=zero, flag_c<=carry;
//    retired<=retired+1, wraps max -> 0 with no saturation.
//  - out_wr_en=0 whenever out_valid=0.
//  - flush=1: next state EMPTY, in_ready=1, buffered entries discarded.
//    flush wins over a simultaneous in_fire. An out_fire in the same cycle
//    still commits flags and retired, since the consumer saw it.
//  - rst_n has priority over flush.
// TESTING
//  - Reset then idle: out_valid=0, in_ready=1, flag_z=0, flag_c=0, retired=0.
//  - Stream 4 entries (0x0001,0x8000,0x0000,0xFFFF), out_ready=1, flag_en=1:
//    each appears 1 cycle later; final flag_z=0, retired=4.
//  - out_ready=0, push 3 entries: first two accepted, in_ready=0 after 2nd.
//    Release: order preserved with no loss or duplicates.
//  - Entry with zero=1, carry=1, flag_en=0 commits: flags unchanged,
//    out_wr_en follows wr_en, retired+1.
//  - FULL, then flush with in_valid=1: next cycle out_valid=0, in_ready=1.
//    Flushed entries never appear at the output.
//  - Preload retired=0xFFFF via 65535 commits, commit one more -> retired=0x0000.

Source files
------------

// File: rtl/ex_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ex_wb_stage
//  Description : ALU execute-to-writeback stage with a 2-entry skid buffer,
//                architectural Z/C status register and retired counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_wb_stage #(
  parameter int DATA_W = 16,
  parameter int RD_W   = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_zero,
  input  logic              in_carry,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_wr_en,
  input  logic              in_flag_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_wr_en,
  output logic              flag_z,
  output logic              flag_c,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              carry;
    logic [RD_W-1:0]   rd;
    logic              wr_en;
    logic              flag_en;
  } entry_t;

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t             r_state;
  state_t             w_state_nxt;
  entry_t             r_main;
  entry_t             r_skid;
  entry_t             w_in_entry;
  logic               r_in_ready;
  logic               r_flag_z;
  logic               r_flag_c;
  logic [CNT_W-1:0]   r_retired;
  logic               w_in_fire;
  logic               w_out_fire;
  logic               w_out_valid;
  logic               w_load_main_in;
  logic               w_load_main_skid;
  logic               w_load_skid;

  assign w_in_entry = '{result:  in_result,
                        zero:    in_zero,
                        carry:   in_carry,
                        rd:      in_rd,
                        wr_en:   in_wr_en,
                        flag_en: in_flag_en};

  assign w_out_valid = (r_state != S_EMPTY);
  assign w_in_fire   = in_valid & r_in_ready;
  assign w_out_fire  = w_out_valid & out_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    unique case (r_state)
      S_EMPTY: begin
        if (w_in_fire) begin
          w_state_nxt    = S_ONE;
          w_load_main_in = 1'b1;
        end
      end
      S_ONE: begin
        if (w_in_fire && w_out_fire) begin
          w_load_main_in = 1'b1;
        end else if (w_in_fire) begin
          w_state_nxt = S_FULL;
          w_load_skid = 1'b1;
        end else if (w_out_fire) begin
          w_state_nxt = S_EMPTY;
        end
      end
      S_FULL: begin
        if (w_out_fire) begin
          w_state_nxt      = S_ONE;
          w_load_main_skid = 1'b1;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
    // Flush discards everything buffered, including a same-cycle accept.
    if (flush) begin
      w_state_nxt      = S_EMPTY;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
      r_main     <= '0;
      r_skid     <= '0;
      r_flag_z   <= 1'b0;
      r_flag_c   <= 1'b0;
      r_retired  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      // Registered ready: known one cycle ahead from the next occupancy.
      r_in_ready <= (w_state_nxt != S_FULL);
      if (w_load_main_in) begin
        r_main <= w_in_entry;
      end else if (w_load_main_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_in_entry;
      end
      // The consumer saw the entry, so it commits even under flush.
      if (w_out_fire) begin
        if (r_main.flag_en) begin
          r_flag_z <= r_main.zero;
          r_flag_c <= r_main.carry;
        end
        r_retired <= r_retired + c_cnt_one;
      end
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = w_out_valid;
  assign out_result = r_main.result;
  assign out_rd     = r_main.rd;
  assign out_wr_en  = w_out_valid & r_main.wr_en;
  assign flag_z     = r_flag_z;
  assign flag_c     = r_flag_c;
  assign retired    = r_retired;

endmodule
`default_nettype wire
